// File: rtl/arith_pkg.sv
// Shared arithmetic-lab definitions: the serial subtractor FSM encoding and default width.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_t;

  localparam int SUB_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bin, with borrow-out bout.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b over WIDTH cycles using a single
// full-subtractor cell and a registered borrow.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH);

  // Handshake: start is a request sampled only in IDLE; the edge that sees it
  // captures a/b. There is no ready signal and no queuing -- requests made while
  // busy or done are dropped. done is a one-cycle valid pulse, diff/borrow hold after.
  sub_state_t       state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bf_q, bf_d;

  logic cell_d;
  logic cell_bout;
  logic last_bit;

  full_subtractor u_cell (
    .x    (ra_q[0]),
    .y    (rb_q[0]),
    .bin  (bf_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    bf_d    = bf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          ra_d    = a;
          rb_d    = b;
          cnt_d   = '0;
          bf_d    = 1'b0;
        end
      end
      SHIFT: begin
        ra_d   = {1'b0, ra_q[WIDTH-1:1]};
        rb_d   = {1'b0, rb_q[WIDTH-1:1]};
        diff_d = {cell_d, diff_q[WIDTH-1:1]};
        bf_d   = cell_bout;
        // The counter parks at WIDTH-1 on the final bit instead of wrapping.
        if (last_bit) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      bf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      bf_q    <= bf_d;
    end
  end

  assign diff      = diff_q;
  assign borrow    = bf_q;
  assign busy      = (state_q == SHIFT);
  assign done      = (state_q == DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor at WIDTH=8 and WIDTH=13 against an arithmetic reference.
module tb_serial_subtractor;
  import arith_pkg::*;

  logic clk;
  logic rst_n;

  logic        start8;
  logic [7:0]  a8, b8, diff8;
  logic        borrow8, busy8, done8;
  logic [1:0]  state8;

  logic        start13;
  logic [12:0] a13, b13, diff13;
  logic        borrow13, busy13, done13;
  logic [1:0]  state13;

  int pass_cnt;
  int total_cnt;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .diff(diff8), .borrow(borrow8), .busy(busy8), .done(done8), .dbg_state(state8)
  );

  serial_subtractor #(.WIDTH(13)) u_dut13 (
    .clk(clk), .rst_n(rst_n), .start(start13), .a(a13), .b(b13),
    .diff(diff13), .borrow(borrow13), .busy(busy13), .done(done13), .dbg_state(state13)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: plain modular arithmetic and an unsigned compare
  function automatic logic [31:0] ref_diff(input int unsigned av, input int unsigned bv, input int w);
    longint m;
    m = longint'(1) << w;
    return 32'(((longint'(av) - longint'(bv)) % m + m) % m);
  endfunction

  function automatic logic ref_borrow(input int unsigned av, input int unsigned bv);
    return av < bv;
  endfunction

  // driver: call right after a negedge with DUT idle
  task automatic op8(input logic [7:0] av, input logic [7:0] bv,
                     output logic [7:0] dv, output logic bo,
                     output int lat, output int busy_n, output bit overlap, output bit done_after);
    dv = '0; bo = 1'b0; lat = -1; busy_n = 0; overlap = 1'b0;
    a8 = av; b8 = bv; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    for (int k = 0; k < 40 && lat < 0; k++) begin
      @(negedge clk);
      if (busy8) busy_n++;
      if (busy8 && done8) overlap = 1'b1;
      if (done8) begin
        lat = k; dv = diff8; bo = borrow8;
      end
    end
    @(negedge clk);
    done_after = done8;
  endtask

  task automatic op13(input logic [12:0] av, input logic [12:0] bv,
                      output logic [12:0] dv, output logic bo, output int lat);
    dv = '0; bo = 1'b0; lat = -1;
    a13 = av; b13 = bv; start13 = 1'b1;
    @(posedge clk);
    #1 start13 = 1'b0;
    for (int k = 0; k < 60 && lat < 0; k++) begin
      @(negedge clk);
      if (done13) begin
        lat = k; dv = diff13; bo = borrow13;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({diff8, borrow8, busy8, done8} !== 11'd0) $display("FAIL reset_outputs: got %h expected 0", {diff8, borrow8, busy8, done8});
    else pass_cnt++;
    total_cnt++;
    if (state8 !== IDLE) $display("FAIL reset_state: got %0d expected %0d", state8, IDLE);
    else pass_cnt++;
    total_cnt++;
    if ({diff13, borrow13, busy13, done13} !== 16'd0) $display("FAIL reset_outputs13: got %h expected 0", {diff13, borrow13, busy13, done13});
    else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] dv; logic bo; int lat, bn; bit ov, da;
    op8(8'h5A, 8'h3C, dv, bo, lat, bn, ov, da);
    total_cnt++; if (dv !== 8'h1E) $display("FAIL basic_diff: got %h expected 1e", dv); else pass_cnt++;
    total_cnt++; if (bo !== 1'b0) $display("FAIL basic_borrow: got %b expected 0", bo); else pass_cnt++;
    total_cnt++; if (lat !== 8) $display("FAIL basic_latency: got %0d expected 8", lat); else pass_cnt++;
    total_cnt++; if (bn !== 8) $display("FAIL basic_busy_cycles: got %0d expected 8", bn); else pass_cnt++;
    total_cnt++; if (ov !== 1'b0) $display("FAIL basic_busy_done_overlap: got %b expected 0", ov); else pass_cnt++;
    total_cnt++; if (da !== 1'b0) $display("FAIL basic_done_pulse: got %b expected 0", da); else pass_cnt++;
    total_cnt++; if (diff8 !== 8'h1E) $display("FAIL basic_diff_hold: got %h expected 1e", diff8); else pass_cnt++;
  endtask

  task automatic test_boundaries();
    logic [7:0] tab_a [5];
    logic [7:0] tab_b [5];
    logic [7:0] dv; logic bo; int lat, bn; bit ov, da;
    tab_a = '{8'h3C, 8'h00, 8'hFF, 8'h80, 8'hA5};
    tab_b = '{8'h5A, 8'h01, 8'hFF, 8'h00, 8'hA5};
    for (int i = 0; i < 5; i++) begin
      op8(tab_a[i], tab_b[i], dv, bo, lat, bn, ov, da);
      total_cnt++;
      if (dv !== 8'(ref_diff(tab_a[i], tab_b[i], 8)))
        $display("FAIL bound_diff[%0d]: got %h expected %h", i, dv, 8'(ref_diff(tab_a[i], tab_b[i], 8)));
      else pass_cnt++;
      total_cnt++;
      if (bo !== ref_borrow(tab_a[i], tab_b[i]))
        $display("FAIL bound_borrow[%0d]: got %b expected %b", i, bo, ref_borrow(tab_a[i], tab_b[i]));
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    a8 = 8'h33; b8 = 8'h11; start8 = 1'b1;
    @(posedge clk);
    lat = -1;
    for (int k = 0; k < 40 && lat < 0; k++) begin
      @(negedge clk);
      if (k == 0) begin a8 = 8'h10; b8 = 8'h01; end
      if (done8) lat = k;
    end
    total_cnt++; if (lat !== 8) $display("FAIL b2b_latency1: got %0d expected 8", lat); else pass_cnt++;
    total_cnt++; if (diff8 !== 8'h22) $display("FAIL b2b_diff1: got %h expected 22", diff8); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if ({busy8, done8} !== 2'b00) $display("FAIL b2b_idle_gap: got %b expected 00", {busy8, done8}); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (busy8 !== 1'b1) $display("FAIL b2b_second_accept: got %b expected 1", busy8); else pass_cnt++;
    start8 = 1'b0;
    lat = -1;
    for (int k = 1; k < 40 && lat < 0; k++) begin
      @(negedge clk);
      if (done8) lat = k;
    end
    total_cnt++; if (lat !== 8) $display("FAIL b2b_latency2: got %0d expected 8", lat); else pass_cnt++;
    total_cnt++; if (diff8 !== 8'h0F) $display("FAIL b2b_diff2: got %h expected 0f", diff8); else pass_cnt++;
    total_cnt++; if (borrow8 !== 1'b0) $display("FAIL b2b_borrow2: got %b expected 0", borrow8); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_abort();
    logic [7:0] dv; logic bo; int lat, bn; bit ov, da; bit seen_done;
    a8 = 8'h5A; b8 = 8'h3C; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({busy8, done8, diff8, borrow8} !== 11'd0)
      $display("FAIL abort_async_clear: got %h expected 0", {busy8, done8, diff8, borrow8});
    else pass_cnt++;
    seen_done = 1'b0;
    repeat (2) begin @(negedge clk); if (done8) seen_done = 1'b1; end
    rst_n = 1'b1;
    repeat (10) begin @(negedge clk); if (done8 || busy8) seen_done = 1'b1; end
    total_cnt++; if (seen_done !== 1'b0) $display("FAIL abort_no_done: got %b expected 0", seen_done); else pass_cnt++;
    op8(8'h07, 8'h09, dv, bo, lat, bn, ov, da);
    total_cnt++; if (dv !== 8'hFE) $display("FAIL abort_fresh_diff: got %h expected fe", dv); else pass_cnt++;
    total_cnt++; if (bo !== 1'b1) $display("FAIL abort_fresh_borrow: got %b expected 1", bo); else pass_cnt++;
  endtask

  task automatic test_random8();
    logic [7:0] av, bv, dv; logic bo; int lat, bn; bit ov, da;
    for (int i = 0; i < 1000; i++) begin
      av = 8'($urandom_range(0, 255));
      bv = (i % 10 == 0) ? av : 8'($urandom_range(0, 255));
      op8(av, bv, dv, bo, lat, bn, ov, da);
      total_cnt++;
      if (dv !== 8'(ref_diff(av, bv, 8)) || lat !== 8)
        $display("FAIL rand8_diff: a=%h b=%h got %h lat %0d expected %h lat 8", av, bv, dv, lat, 8'(ref_diff(av, bv, 8)));
      else pass_cnt++;
      total_cnt++;
      if (bo !== ref_borrow(av, bv)) $display("FAIL rand8_borrow: a=%h b=%h got %b expected %b", av, bv, bo, ref_borrow(av, bv));
      else pass_cnt++;
    end
  endtask

  task automatic test_random13();
    logic [12:0] av, bv, dv; logic bo; int lat;
    for (int i = 0; i < 1000; i++) begin
      av = 13'($urandom_range(0, 8191));
      bv = (i % 10 == 0) ? 13'd0 : 13'($urandom_range(0, 8191));
      op13(av, bv, dv, bo, lat);
      total_cnt++;
      if (dv !== 13'(ref_diff(av, bv, 13)) || lat !== 13)
        $display("FAIL rand13_diff: a=%h b=%h got %h lat %0d expected %h lat 13", av, bv, dv, lat, 13'(ref_diff(av, bv, 13)));
      else pass_cnt++;
      total_cnt++;
      if (bo !== ref_borrow(av, bv)) $display("FAIL rand13_borrow: a=%h b=%h got %b expected %b", av, bv, bo, ref_borrow(av, bv));
      else pass_cnt++;
    end
  endtask

  initial begin
    pass_cnt = 0; total_cnt = 0;
    start8 = 1'b0; a8 = '0; b8 = '0;
    start13 = 1'b0; a13 = '0; b13 = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_boundaries();
    test_back_to_back();
    test_abort();
    test_random8();
    test_random13();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
